// File: rtl/data_sram_mmio_resp.sv
// data_sram_mmio_resp: splits CPU data-port requests between a small local
// register window (LED, 7-seg, switches, timer, byte TX, scratch) and the
// data RAM. Both paths answer with the same one-cycle synchronous timing,
// so the CPU sees a single uniform SRAM port.
module data_sram_mmio_resp #(
  parameter logic [15:0] MMIO_BASE = 16'hBFAF,
  parameter int unsigned TX_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [15:0] led,
  output logic [31:0] num,
  input  logic [7:0]  switch,
  output logic [7:0]  tx_data,
  output logic        tx_valid
);

  localparam int CW = $clog2(TX_CYCLES + 1);

  localparam logic [15:0] OFF_LED = 16'hF000;
  localparam logic [15:0] OFF_NUM = 16'hF010;
  localparam logic [15:0] OFF_SW  = 16'hF020;
  localparam logic [15:0] OFF_TMR = 16'hF030;
  localparam logic [15:0] OFF_TXD = 16'hF040;
  localparam logic [15:0] OFF_TXS = 16'hF044;
  localparam logic [15:0] OFF_SCR = 16'hF050;

  logic          hit;
  logic          wr_any;
  logic [15:0]   off;
  logic [31:0]   wmask;
  logic [31:0]   scratch;
  logic [31:0]   timer;
  logic [7:0]    sw_meta;
  logic [7:0]    sw_sync;
  logic [CW-1:0] tx_cnt;
  logic          tx_ovf;
  logic          busy;
  logic          tx_go;
  logic          tx_drop;
  logic          ovf_clr;
  logic          sel_q;
  logic [31:0]   rdata_q;
  logic [31:0]   rd_val;

  // Byte-lane merge: old value keeps lanes whose wen bit is clear.
  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [31:0] m);
    return (old & ~m) | (d & m);
  endfunction

  assign hit    = data_sram_en & (data_sram_addr[31:16] == MMIO_BASE);
  assign off    = data_sram_addr[15:0];
  assign wr_any = hit & (|data_sram_wen);

  // Expand per-byte write enables into a bit mask.
  genvar b;
  for (b = 0; b < 4; b++) begin : g_mask
    assign wmask[8*b +: 8] = {8{data_sram_wen[b]}};
  end

  // RAM side sees the request untouched; only the enable is gated by the window.
  assign ram_en    = data_sram_en & ~hit;
  assign ram_wen   = data_sram_wen;
  assign ram_addr  = data_sram_addr;
  assign ram_wdata = data_sram_wdata;

  assign busy    = (tx_cnt != '0);
  assign tx_go   = hit & (off == OFF_TXD) & data_sram_wen[0] & ~busy;
  assign tx_drop = hit & (off == OFF_TXD) & data_sram_wen[0] & busy;
  assign ovf_clr = hit & (off == OFF_TXS) & data_sram_wen[0] & data_sram_wdata[1];

  // LED register: only the low two byte lanes exist.
  always_ff @(posedge clk) begin
    if (reset)
      led <= '0;
    else if (wr_any && off == OFF_LED)
      led <= (led & ~wmask[15:0]) | (data_sram_wdata[15:0] & wmask[15:0]);
  end

  // 7-segment value and scratch registers, full 32-bit byte-writable.
  always_ff @(posedge clk) begin
    if (reset) begin
      num     <= '0;
      scratch <= '0;
    end else begin
      if (wr_any && off == OFF_NUM) num     <= merge(num, data_sram_wdata, wmask);
      if (wr_any && off == OFF_SCR) scratch <= merge(scratch, data_sram_wdata, wmask);
    end
  end

  // Free-running timer; a write loads the merged value instead of counting.
  always_ff @(posedge clk) begin
    if (reset)
      timer <= '0;
    else if (wr_any && off == OFF_TMR)
      timer <= merge(timer, data_sram_wdata, wmask);
    else
      timer <= timer + 32'd1;
  end

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
    end
  end

  // Byte transmitter: accept when idle, hold busy for TX_CYCLES, flag drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_cnt   <= '0;
      tx_ovf   <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (busy) tx_cnt <= tx_cnt - 1'b1;
      if (tx_go) begin
        tx_data  <= data_sram_wdata[7:0];
        tx_valid <= 1'b1;
        tx_cnt   <= CW'(TX_CYCLES);
      end
      if (tx_drop)      tx_ovf <= 1'b1;
      else if (ovf_clr) tx_ovf <= 1'b0;
    end
  end

  // Register read mux: pre-write values; write-only and holes read zero.
  always_comb begin
    rd_val = '0;
    case (off)
      OFF_LED: rd_val = {16'b0, led};
      OFF_NUM: rd_val = num;
      OFF_SW:  rd_val = {24'b0, sw_sync};
      OFF_TMR: rd_val = timer;
      OFF_TXS: rd_val = {30'b0, tx_ovf, busy};
      OFF_SCR: rd_val = scratch;
      default: rd_val = '0;
    endcase
  end

  // Response path state: remember which side answers and the window's data.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q   <= 1'b0;
      rdata_q <= '0;
    end else if (data_sram_en) begin
      sel_q <= hit;
      if (hit) rdata_q <= rd_val;
    end
  end

  assign data_sram_rdata = sel_q ? rdata_q : ram_rdata;

endmodule

// File: tb/tb_data_sram_mmio_resp.sv
// Bench for data_sram_mmio_resp: a synchronous RAM stand-in plus a
// cycle-indexed reference model of the register window.
module tb_data_sram_mmio_resp;
  localparam logic [15:0] BASE = 16'hBFAF;
  localparam int TXC = 16;
  localparam logic [31:0] RAMB = 32'h1C000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  wen = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [15:0] led;
  logic [31:0] num;
  logic [7:0]  sw = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;

  always #5 clk = ~clk;

  data_sram_mmio_resp #(.MMIO_BASE(BASE), .TX_CYCLES(TXC)) dut (
    .clk(clk), .reset(reset),
    .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_rdata(rdata),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .led(led), .num(num), .switch(sw),
    .tx_data(tx_data), .tx_valid(tx_valid)
  );

  // Data RAM stand-in: one-cycle read latency, read-before-write, holds douta.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr[11:2]];
      for (int i = 0; i < 4; i++)
        if (ram_wen[i]) mem[ram_addr[11:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  // Reference model state, expressed per cycle number.
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_led;
  logic [31:0] m_num, m_scr, t_ref;
  int          t_cyc;
  logic [7:0]  m_txd;
  logic        m_ovf;
  int          tx_w;
  logic [7:0]  sw_old, sw_new;
  int          sw_cyc;
  logic [31:0] ref_ram [int];

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] m);
    logic [31:0] r = o;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_timer(input int c);
    return t_ref + 32'(c - t_cyc);
  endfunction

  function automatic bit m_busy(input int c);
    return (c > tx_w) && (c <= tx_w + TXC);
  endfunction

  function automatic logic [31:0] m_switch(input int c);
    return {24'b0, (c >= sw_cyc + 2) ? sw_new : sw_old};
  endfunction

  function automatic int rkey(input logic [31:0] a);
    return int'({2'b00, a[31:2]});
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input int c);
    if (a[31:16] != BASE) return ref_ram.exists(rkey(a)) ? ref_ram[rkey(a)] : 32'h0;
    case (a[15:0])
      16'hF000: return {16'b0, m_led};
      16'hF010: return m_num;
      16'hF020: return m_switch(c);
      16'hF030: return m_timer(c);
      16'hF044: return {30'b0, m_ovf, m_busy(c)};
      16'hF050: return m_scr;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [3:0] w,
                         input logic [31:0] d, input int c);
    logic [31:0] t;
    if (a[31:16] != BASE) begin
      if (|w) ref_ram[rkey(a)] = bmerge(ref_ram.exists(rkey(a)) ? ref_ram[rkey(a)] : 32'h0, d, w);
      return;
    end
    case (a[15:0])
      16'hF000: begin t = bmerge({16'b0, m_led}, d, {2'b00, w[1:0]}); m_led = t[15:0]; end
      16'hF010: m_num = bmerge(m_num, d, w);
      16'hF030: if (|w) begin t_ref = bmerge(m_timer(c), d, w); t_cyc = c + 1; end
      16'hF040: if (w[0]) begin
        if (m_busy(c)) m_ovf = 1'b1;
        else begin m_txd = d[7:0]; tx_w = c; end
      end
      16'hF044: if (w[0] && d[1]) m_ovf = 1'b0;
      16'hF050: m_scr = bmerge(m_scr, d, w);
      default: ;
    endcase
  endtask

  task automatic m_reset();
    m_led = '0; m_num = '0; m_scr = '0; m_txd = '0; m_ovf = 1'b0;
    t_ref = '0; t_cyc = cyc; tx_w = -1000;
    sw_old = '0; sw_new = sw; sw_cyc = cyc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    en = 1'b0; wen = '0;
    repeat (n) tick();
  endtask

  // One request cycle; returns the model's expectation, the response seen
  // one cycle later, and the RAM enable seen during the request.
  task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] exp, output logic [31:0] got, output logic ren);
    int c = cyc;
    exp = m_read(a, c);
    en = 1'b1; wen = w; addr = a; wdata = d;
    #1 ren = ram_en;
    tick();
    en = 1'b0; wen = '0;
    got = rdata;
    m_write(a, w, d, c);
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; wen = '0;
    tick(); tick();
    reset = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    logic [31:0] e, g; logic r;
    checks++; if (led !== 16'h0 || num !== 32'h0) begin errors++;
      $display("FAIL reset_regs led=%h num=%h want 0", led, num); end
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h0) begin errors++;
      $display("FAIL reset_tx valid=%b data=%h want 0", tx_valid, tx_data); end
    checks++; if (rdata !== ram_rdata) begin errors++;
      $display("FAIL reset_rdata got=%h want ram_rdata=%h", rdata, ram_rdata); end
    req(4'h0, {BASE, 16'hF044}, 0, e, g, r);
    checks++; if (g !== 32'h0) begin errors++;
      $display("FAIL reset_txstat got=%h want 0", g); end
    req(4'h0, {BASE, 16'hF030}, 0, e, g, r);
    checks++; if (g !== e) begin errors++;
      $display("FAIL reset_timer got=%h want %h", g, e); end
  endtask

  task automatic test_led();
    logic [31:0] e, g, a, d; logic r; logic [3:0] w;
    req(4'hF, {BASE, 16'hF000}, 32'h1234ABCD, e, g, r);
    req(4'h0, {BASE, 16'hF000}, 0, e, g, r);
    checks++; if (g !== 32'h0000ABCD || led !== 16'hABCD) begin errors++;
      $display("FAIL led_full rdata=%h led=%h want 0000abcd/abcd", g, led); end
    req(4'b0010, {BASE, 16'hF000}, 32'h0000FF00, e, g, r);
    checks++; if (led !== 16'hFFCD) begin errors++;
      $display("FAIL led_byte1 led=%h want ffcd", led); end
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 2))
        0: a = {BASE, 16'hF000};
        1: a = {BASE, 16'hF010};
        default: a = {BASE, 16'hF050};
      endcase
      w = 4'($urandom); d = $urandom;
      req(w, a, d, e, g, r);
      req(4'h0, a, 0, e, g, r);
      checks++; if (g !== e || led !== m_led || num !== m_num) begin errors++;
        $display("FAIL rw_rand a=%h got=%h want %h led=%h/%h num=%h/%h",
                 a, g, e, led, m_led, num, m_num); end
    end
  endtask

  task automatic test_timer();
    logic [31:0] e, g1, g2, g; logic r;
    req(4'h0, {BASE, 16'hF030}, 0, e, g1, r);
    checks++; if (g1 !== e) begin errors++;
      $display("FAIL timer_read got=%h want %h", g1, e); end
    idle(4);
    req(4'h0, {BASE, 16'hF030}, 0, e, g2, r);
    checks++; if (g2 - g1 !== 32'd5) begin errors++;
      $display("FAIL timer_delta got=%0d want 5", g2 - g1); end
    req(4'hF, {BASE, 16'hF030}, 32'hFFFFFFFE, e, g, r);
    req(4'h0, {BASE, 16'hF030}, 0, e, g, r);
    checks++; if (g !== 32'hFFFFFFFE) begin errors++;
      $display("FAIL timer_load got=%h want fffffffe", g); end
    req(4'h0, {BASE, 16'hF030}, 0, e, g, r);
    checks++; if (g !== 32'hFFFFFFFF) begin errors++;
      $display("FAIL timer_inc got=%h want ffffffff", g); end
    req(4'h0, {BASE, 16'hF030}, 0, e, g, r);
    checks++; if (g !== 32'h0) begin errors++;
      $display("FAIL timer_wrap got=%h want 0", g); end
    req(4'b0001, {BASE, 16'hF030}, 32'h00000055, e, g, r);
    req(4'h0, {BASE, 16'hF030}, 0, e, g, r);
    checks++; if (g !== e) begin errors++;
      $display("FAIL timer_byte got=%h want %h", g, e); end
  endtask

  task automatic test_tx();
    logic [31:0] e, g; logic r;
    req(4'h1, {BASE, 16'hF040}, 32'h41, e, g, r);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++;
      $display("FAIL tx_accept valid=%b data=%h want 1/41", tx_valid, tx_data); end
    idle(1);
    checks++; if (tx_valid !== 1'b0) begin errors++;
      $display("FAIL tx_pulse_len valid=%b want 0", tx_valid); end
    idle(2);
    req(4'h1, {BASE, 16'hF040}, 32'h42, e, g, r);
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h41) begin errors++;
      $display("FAIL tx_drop valid=%b data=%h want 0/41", tx_valid, tx_data); end
    req(4'h0, {BASE, 16'hF044}, 0, e, g, r);
    checks++; if (g !== 32'h3 || g !== e) begin errors++;
      $display("FAIL tx_ovf got=%h want 3", g); end
    req(4'h1, {BASE, 16'hF044}, 32'h2, e, g, r);
    req(4'h0, {BASE, 16'hF044}, 0, e, g, r);
    checks++; if (g !== 32'h1) begin errors++;
      $display("FAIL tx_w1c got=%h want 1", g); end
    idle(8);
    req(4'h0, {BASE, 16'hF044}, 0, e, g, r);
    checks++; if (g !== 32'h1) begin errors++;
      $display("FAIL tx_busy_last got=%h want 1", g); end
    req(4'h0, {BASE, 16'hF044}, 0, e, g, r);
    checks++; if (g !== 32'h0) begin errors++;
      $display("FAIL tx_idle got=%h want 0", g); end
    req(4'h1, {BASE, 16'hF040}, 32'h43, e, g, r);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h43) begin errors++;
      $display("FAIL tx_reaccept valid=%b data=%h want 1/43", tx_valid, tx_data); end
    idle(15);
    req(4'h1, {BASE, 16'hF040}, 32'h44, e, g, r);
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h43) begin errors++;
      $display("FAIL tx_edge_drop valid=%b data=%h want 0/43", tx_valid, tx_data); end
    req(4'h1, {BASE, 16'hF040}, 32'h45, e, g, r);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h45) begin errors++;
      $display("FAIL tx_edge_accept valid=%b data=%h want 1/45", tx_valid, tx_data); end
    req(4'h1, {BASE, 16'hF044}, 32'h2, e, g, r);
    checks++; if (g !== e) begin errors++;
      $display("FAIL tx_stat_model got=%h want %h", g, e); end
    idle(20);
  endtask

  task automatic test_back_to_back();
    logic [31:0] e, g, a; logic r;
    for (int i = 0; i < 16; i++) req(4'hF, RAMB + 32'(4 * i), $urandom, e, g, r);
    req(4'hF, {BASE, 16'hF050}, $urandom, e, g, r);
    for (int i = 0; i < 24; i++) begin
      a = (i % 2 == 0) ? RAMB + 32'(4 * $urandom_range(0, 15)) : {BASE, 16'hF050};
      req(4'h0, a, 0, e, g, r);
      checks++; if (g !== e || r !== (i % 2 == 0)) begin errors++;
        $display("FAIL alt a=%h got=%h want %h ram_en=%b", a, g, e, r); end
    end
    idle(3);
    checks++; if (rdata !== e) begin errors++;
      $display("FAIL hold_mmio got=%h want %h", rdata, e); end
    req(4'h0, RAMB + 32'h8, 0, e, g, r);
    idle(3);
    checks++; if (rdata !== e) begin errors++;
      $display("FAIL hold_ram got=%h want %h", rdata, e); end
  endtask

  task automatic test_switch();
    logic [31:0] e, g; logic r;
    sw = 8'hA5; sw_old = sw_new; sw_new = 8'hA5; sw_cyc = cyc;
    for (int i = 0; i < 3; i++) begin
      req(4'h0, {BASE, 16'hF020}, 0, e, g, r);
      checks++; if (g !== e) begin errors++;
        $display("FAIL switch_sync%0d got=%h want %h", i, g, e); end
    end
    checks++; if (g !== 32'h000000A5) begin errors++;
      $display("FAIL switch_val got=%h want a5", g); end
    req(4'hF, {BASE, 16'hF100}, 32'hFFFFFFFF, e, g, r);
    req(4'h0, {BASE, 16'hF100}, 0, e, g, r);
    checks++; if (g !== 32'h0) begin errors++;
      $display("FAIL unmapped got=%h want 0", g); end
    req(4'h0, {BASE, 16'hF040}, 0, e, g, r);
    checks++; if (g !== 32'h0) begin errors++;
      $display("FAIL txdata_wo got=%h want 0", g); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e, g; logic r;
    req(4'h3, {BASE, 16'hF000}, 32'h0000FFFF, e, g, r);
    req(4'hF, {BASE, 16'hF010}, 32'h12345678, e, g, r);
    req(4'h1, {BASE, 16'hF040}, 32'h5A, e, g, r);
    idle(3);
    reset = 1'b1;
    en = 1'b1; wen = 4'hF; addr = {BASE, 16'hF010}; wdata = 32'hDEADBEEF;
    tick();
    en = 1'b0; wen = '0; reset = 1'b0;
    m_reset();
    checks++; if (led !== 16'h0 || num !== 32'h0 || tx_data !== 8'h0 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid led=%h num=%h txd=%h txv=%b want 0",
                         led, num, tx_data, tx_valid); end
    checks++; if (rdata !== ram_rdata) begin errors++;
      $display("FAIL reset_mid_rdata got=%h want %h", rdata, ram_rdata); end
    req(4'h0, {BASE, 16'hF044}, 0, e, g, r);
    checks++; if (g !== 32'h0) begin errors++;
      $display("FAIL reset_mid_busy got=%h want 0", g); end
    req(4'h1, {BASE, 16'hF040}, 32'h77, e, g, r);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin errors++;
      $display("FAIL reset_mid_tx valid=%b data=%h want 1/77", tx_valid, tx_data); end
  endtask

  task automatic test_random();
    logic [31:0] e, g, a; logic r; logic [3:0] w;
    logic [15:0] offs [8] = '{16'hF000, 16'hF010, 16'hF020, 16'hF030,
                              16'hF040, 16'hF044, 16'hF050, 16'hF100};
    for (int i = 0; i < 16; i++) req(4'hF, RAMB + 32'(4 * i), $urandom, e, g, r);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        idle(1);
      end else begin
        a = ($urandom_range(0, 2) == 0) ? RAMB + 32'(4 * $urandom_range(0, 15))
                                        : {BASE, offs[$urandom_range(0, 7)]};
        w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        req(w, a, $urandom, e, g, r);
        checks++; if (g !== e || r !== (a[31:16] != BASE)) begin errors++;
          $display("FAIL rand a=%h w=%h got=%h want %h ram_en=%b", a, w, g, e, r); end
      end
      checks++; if (tx_valid !== (tx_w == cyc - 1) || tx_data !== m_txd ||
                    led !== m_led || num !== m_num) begin errors++;
        $display("FAIL rand_out txv=%b txd=%h/%h led=%h/%h num=%h/%h",
                 tx_valid, tx_data, m_txd, led, m_led, num, m_num); end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_led();
    test_timer();
    test_tx();
    test_back_to_back();
    test_switch();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
